imem_loader: RTL

Program loader: the write-side counterpart of the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 9-bit instruction words from byte pairs. It writes each word into the instruction memory write port at consecutive addresses starting at 0. It reports program length, completion and format/overflow errors, and holds `busy` high so the core stays in reset until loading ends.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state type for the instruction memory loader
// Contents:
//   IMEM_ADDR_W, IMEM_INSTR_W : default address and instruction widths
//   LAST_BIT, HI_DATA_BIT     : bit positions inside the second byte of a pair
//   RESERVED_MASK             : bits of the second byte that must be zero
//   loader_state_t            : loader FSM states
package imem_pkg;

  localparam int IMEM_ADDR_W  = 8;
  localparam int IMEM_INSTR_W = 9;

  localparam int LAST_BIT    = 7;
  localparam int HI_DATA_BIT = 0;

  localparam logic [7:0] RESERVED_MASK = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader driving the instruction memory write port
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   i_start             : pulse that begins a load (honoured in IDLE, DONE, ERR)
//   i_in_data/i_in_valid/o_in_ready : byte stream, transfer on valid && ready
//   o_mem_we/o_mem_addr/o_mem_wdata : instruction memory write port
//   o_busy              : loading in progress (holds the core in reset)
//   o_load_done         : last load ended with a LAST-flagged word
//   o_error             : last load ended on a format error or overflow
//   o_prog_len          : words written by the last completed/aborted load
import imem_pkg::*;

module imem_loader #(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DEPTH   = 256,
  parameter int INSTR_W = IMEM_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [7:0]         i_in_data,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [INSTR_W-1:0] o_mem_wdata,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_error,
  output logic [ADDR_W:0]    o_prog_len
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [ADDR_W-1:0]  r_wptr;
  logic [ADDR_W:0]    r_count;
  logic [7:0]         r_lo_byte;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_last;
  logic [ADDR_W:0]    r_prog_len;

  logic w_in_ready;
  logic w_xfer;
  logic w_bad_fmt;
  logic w_start_ok;

  assign w_in_ready = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_xfer     = i_in_valid && w_in_ready;
  assign w_bad_fmt  = (i_in_data & RESERVED_MASK) != 8'h00;
  assign w_start_ok = i_start &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          w_next = ST_LO;
        end
      end
      ST_LO: begin
        if (w_xfer) begin
          w_next = ST_HI;
        end
      end
      ST_HI: begin
        if (w_xfer) begin
          w_next = w_bad_fmt ? ST_ERR : ST_WR;
        end
      end
      ST_WR: begin
        if (r_last) begin
          w_next = ST_DONE;
        end else if (r_wptr == LAST_ADDR) begin
          // Memory is full and more words are coming: stop rather than wrap
          w_next = ST_ERR;
        end else begin
          w_next = ST_LO;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte assembler, write pointer and length bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_count    <= '0;
      r_lo_byte  <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_prog_len <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // prog_len is deliberately kept so the previous result stays visible
          if (w_start_ok) begin
            r_wptr  <= '0;
            r_count <= '0;
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_lo_byte <= i_in_data;
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            if (w_bad_fmt) begin
              r_prog_len <= r_count;
            end else begin
              r_wdata <= {i_in_data[HI_DATA_BIT], r_lo_byte};
              r_last  <= i_in_data[LAST_BIT];
            end
          end
        end
        ST_WR: begin
          if (r_last) begin
            r_prog_len <= r_count + 1'b1;
          end else if (r_wptr == LAST_ADDR) begin
            r_prog_len <= FULL_LEN;
          end else begin
            r_wptr  <= r_wptr + 1'b1;
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once
  assign o_in_ready  = w_in_ready;
  assign o_mem_we    = (r_state == ST_WR);
  assign o_mem_addr  = r_wptr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_WR);
  assign o_load_done = (r_state == ST_DONE);
  assign o_error     = (r_state == ST_ERR);
  assign o_prog_len  = r_prog_len;

endmodule
